// File: rtl/iface_lane_collector_if.sv
// Lane-side and output-side handshake bundle for the lane collector.
// The collector connects to the slave modport; the driving side uses master.
interface iface_lane_collector_if #(
    parameter int N = 4
) ();
    localparam int IW = $clog2(N);

    logic [N-1:0]   lane_data;
    logic [8*N-1:0] lane_value;
    logic [N-1:0]   lane_ack;
    logic           out_valid;
    logic           out_ready;
    logic [IW-1:0]  out_idx;
    logic [7:0]     out_value;

    modport slave (
        input  lane_data,
        input  lane_value,
        input  out_ready,
        output lane_ack,
        output out_valid,
        output out_idx,
        output out_value
    );

    modport master (
        output lane_data,
        output lane_value,
        output out_ready,
        input  lane_ack,
        input  out_valid,
        input  out_idx,
        input  out_value
    );
endinterface

// File: rtl/iface_lane_collector.sv
// Round-robin lane collector: grants one requesting lane per cycle, queues
// {lane index, value} in a FIFO and keeps a running sum and a stall counter.
module iface_lane_collector #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    iface_lane_collector_if.slave    bus,
    output logic [7:0]               sum_out,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              stall_cnt
);
    localparam int IW = $clog2(N);
    localparam int AW = $clog2(DEPTH);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [7:0]    sum_q, sum_d;
    logic [15:0]   stall_q, stall_d;
    logic [IW-1:0] idx_mem_q [DEPTH];
    logic [IW-1:0] idx_mem_d [DEPTH];
    logic [7:0]    val_mem_q [DEPTH];
    logic [7:0]    val_mem_d [DEPTH];

    logic          full;
    logic          grant_vld;
    logic          pop;
    logic [IW-1:0] grant;
    logic [IW-1:0] cand;

    // Fullness comes from registered level, so a pop never frees a slot for the same cycle.
    always_comb begin
        full      = (level_q == (AW+1)'(DEPTH));
        grant_vld = 1'b0;
        grant     = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = ptr_q + IW'(k);
            if (!grant_vld && bus.lane_data[cand]) begin
                grant_vld = 1'b1;
                grant     = cand;
            end
        end
        if (full || !rst_n) begin
            grant_vld = 1'b0;
        end
        bus.lane_ack = grant_vld ? (N'(1) << grant) : '0;
    end

    always_comb begin
        bus.out_valid = (level_q != '0);
        bus.out_idx   = idx_mem_q[rd_ptr_q];
        bus.out_value = val_mem_q[rd_ptr_q];
        pop           = bus.out_valid & bus.out_ready;
    end

    always_comb begin
        ptr_d     = ptr_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        sum_d     = sum_q;
        stall_d   = stall_q;
        idx_mem_d = idx_mem_q;
        val_mem_d = val_mem_q;

        if (grant_vld) begin
            ptr_d               = grant + IW'(1);
            wr_ptr_d            = wr_ptr_q + AW'(1);
            idx_mem_d[wr_ptr_q] = grant;
            val_mem_d[wr_ptr_q] = bus.lane_value[{grant, 3'b000} +: 8];
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            sum_d    = sum_q + bus.out_value;
        end

        case ({grant_vld, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase

        if (full && (|bus.lane_data) && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            sum_q    <= '0;
            stall_q  <= '0;
        end else begin
            ptr_q    <= ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            sum_q    <= sum_d;
            stall_q  <= stall_d;
        end
    end

    // Storage needs no reset; emptiness is tracked by level and the pointers.
    always_ff @(posedge clk) begin
        idx_mem_q <= idx_mem_d;
        val_mem_q <= val_mem_d;
    end

    assign sum_out   = sum_q;
    assign level     = level_q;
    assign stall_cnt = stall_q;
endmodule

// File: tb/tb_iface_lane_collector.sv
// Bench for iface_lane_collector: per-cycle queue model of the FIFO plus
// a vector table and hand-written corner-case sequences.
module tb_iface_lane_collector;
    localparam int N     = 4;
    localparam int DEPTH = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  sum_out;
    logic [2:0]  level;
    logic [15:0] stall_cnt;

    iface_lane_collector_if #(.N(N)) bus ();

    iface_lane_collector #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .sum_out   (sum_out),
        .level     (level),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] idx;
        logic [7:0] val;
    } entry_t;

    typedef struct {
        logic [3:0]  data;
        logic [31:0] value;
        logic        ready;
        logic [3:0]  exp_ack;
        logic [2:0]  exp_level;
        logic [7:0]  exp_sum;
        logic        exp_valid;
        logic [1:0]  exp_idx;
        logic [7:0]  exp_val;
    } vec_t;

    entry_t      sb[$];
    int          m_ptr;
    logic [7:0]  m_sum;
    logic [15:0] m_stall;
    bit          model_on = 1'b0;
    bit          m_full;
    bit          found;
    int          g;
    int          cidx;
    logic [3:0]  e_ack;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] d, input logic [31:0] v, input logic r);
        bus.lane_data  = d;
        bus.lane_value = v;
        bus.out_ready  = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(4'b0000, 32'h0, 1'b0);
        step();
        rst_n = 1'b1;
    endtask

    // Reference model: sb holds the expected FIFO contents, updated once per cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            if (model_on) begin
                checkOutput("ack_in_reset", 32'(bus.lane_ack), 32'h0);
            end
            sb.delete();
            m_ptr    = 0;
            m_sum    = 8'h00;
            m_stall  = 16'h0000;
            model_on = 1'b1;
        end else if (model_on) begin
            m_full = (sb.size() == DEPTH);
            found  = 1'b0;
            g      = 0;
            if (!m_full) begin
                for (int k = 0; k < N; k++) begin
                    cidx = (m_ptr + k) % N;
                    if (!found && bus.lane_data[cidx]) begin
                        found = 1'b1;
                        g     = cidx;
                    end
                end
            end
            e_ack = found ? 4'(1 << g) : 4'b0000;
            checkOutput("sb_ack", 32'(bus.lane_ack), 32'(e_ack));
            checkOutput("sb_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
            checkOutput("sb_level", 32'(level), 32'(sb.size()));
            checkOutput("sb_sum", 32'(sum_out), 32'(m_sum));
            checkOutput("sb_stall", 32'(stall_cnt), 32'(m_stall));
            if (sb.size() != 0) begin
                checkOutput("sb_idx", 32'(bus.out_idx), 32'(sb[0].idx));
                checkOutput("sb_value", 32'(bus.out_value), 32'(sb[0].val));
            end
            if (m_full && (|bus.lane_data) && (m_stall != 16'hFFFF)) begin
                m_stall = m_stall + 16'd1;
            end
            if ((sb.size() != 0) && bus.out_ready) begin
                m_sum = m_sum + sb[0].val;
                void'(sb.pop_front());
            end
            if (found) begin
                sb.push_back('{idx: 2'(g), val: bus.lane_value[8*g +: 8]});
                m_ptr = (g + 1) % N;
            end
        end
    end

    initial begin
        vec_t       vecs[6];
        logic [3:0] wrap_ack[14];
        logic [31:0] v;

        vecs[0] = '{4'b1111, 32'hFF020100, 1'b1, 4'b0001, 3'd0, 8'h00, 1'b0, 2'd0, 8'h00};
        vecs[1] = '{4'b1110, 32'hFF020100, 1'b1, 4'b0010, 3'd1, 8'h00, 1'b1, 2'd0, 8'h00};
        vecs[2] = '{4'b1100, 32'hFF020100, 1'b1, 4'b0100, 3'd1, 8'h00, 1'b1, 2'd1, 8'h01};
        vecs[3] = '{4'b1000, 32'hFF020100, 1'b1, 4'b1000, 3'd1, 8'h01, 1'b1, 2'd2, 8'h02};
        vecs[4] = '{4'b0000, 32'hFF020100, 1'b1, 4'b0000, 3'd1, 8'h03, 1'b1, 2'd3, 8'hFF};
        vecs[5] = '{4'b0000, 32'hFF020100, 1'b1, 4'b0000, 3'd0, 8'h02, 1'b0, 2'd0, 8'h00};

        wrap_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0000,
                     4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0010};

        applyStimulus(4'b0000, 32'h0, 1'b0);
        step();
        doReset();

        // Order and sum through the vector table.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].data, vecs[i].value, vecs[i].ready);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_ack", i), 32'(bus.lane_ack), 32'(vecs[i].exp_ack));
            checkOutput($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
            checkOutput($sformatf("vec%0d_sum", i), 32'(sum_out), 32'(vecs[i].exp_sum));
            checkOutput($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                checkOutput($sformatf("vec%0d_idx", i), 32'(bus.out_idx), 32'(vecs[i].exp_idx));
                checkOutput($sformatf("vec%0d_val", i), 32'(bus.out_value), 32'(vecs[i].exp_val));
            end
            step();
        end

        // Round-robin fairness between lanes 1 and 3.
        doReset();
        v = 32'h30001000;
        applyStimulus(4'b1010, v, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput($sformatf("rr_ack%0d", i), 32'(bus.lane_ack), (i % 2 == 0) ? 32'h2 : 32'h8);
            step();
        end
        applyStimulus(4'b0000, v, 1'b1);
        repeat (3) step();
        @(negedge clk);
        checkOutput("rr_sum", 32'(sum_out), 32'hC0);
        checkOutput("rr_level", 32'(level), 32'h0);
        step();

        // Full FIFO with backpressure, then a single pop.
        doReset();
        v = 32'h00640000;
        applyStimulus(4'b0100, v, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput($sformatf("full_ack%0d", i), 32'(bus.lane_ack), (i < 4) ? 32'h4 : 32'h0);
            checkOutput($sformatf("full_level%0d", i), 32'(level), (i < 4) ? 32'(i) : 32'h4);
            step();
        end
        applyStimulus(4'b0100, v, 1'b1);
        @(negedge clk);
        checkOutput("full_stall", 32'(stall_cnt), 32'h4);
        checkOutput("full_pop_ack", 32'(bus.lane_ack), 32'h0);
        checkOutput("full_pop_level", 32'(level), 32'h4);
        step();
        applyStimulus(4'b0100, v, 1'b0);
        @(negedge clk);
        checkOutput("after_pop_level", 32'(level), 32'h3);
        checkOutput("after_pop_ack", 32'(bus.lane_ack), 32'h4);
        step();
        @(negedge clk);
        checkOutput("refill_level", 32'(level), 32'h4);
        applyStimulus(4'b0000, v, 1'b1);
        repeat (5) step();

        // Simultaneous push and pop at level 2.
        doReset();
        v = 32'h0022110A;
        applyStimulus(4'b0110, v, 1'b0);
        @(negedge clk);
        checkOutput("pp_ack0", 32'(bus.lane_ack), 32'h2);
        step();
        applyStimulus(4'b0100, v, 1'b0);
        @(negedge clk);
        checkOutput("pp_ack1", 32'(bus.lane_ack), 32'h4);
        step();
        applyStimulus(4'b0001, v, 1'b1);
        @(negedge clk);
        checkOutput("pp_level_a", 32'(level), 32'h2);
        checkOutput("pp_ack2", 32'(bus.lane_ack), 32'h1);
        checkOutput("pp_head_a", {22'h0, bus.out_idx, bus.out_value}, 32'h111);
        step();
        applyStimulus(4'b0000, v, 1'b1);
        @(negedge clk);
        checkOutput("pp_level_b", 32'(level), 32'h2);
        checkOutput("pp_head_b", {22'h0, bus.out_idx, bus.out_value}, 32'h222);
        checkOutput("pp_sum_b", 32'(sum_out), 32'h11);
        step();
        @(negedge clk);
        checkOutput("pp_head_c", {22'h0, bus.out_idx, bus.out_value}, 32'h00A);
        checkOutput("pp_sum_c", 32'(sum_out), 32'h33);
        step();
        @(negedge clk);
        checkOutput("pp_level_d", 32'(level), 32'h0);
        checkOutput("pp_sum_d", 32'(sum_out), 32'h3D);
        step();

        // Reset in the middle of operation, with the lane pointer away from 0.
        doReset();
        v = 32'h04030205;
        applyStimulus(4'b0001, v, 1'b1);
        step();
        applyStimulus(4'b0000, v, 1'b1);
        step();
        applyStimulus(4'b0010, v, 1'b0);
        step();
        applyStimulus(4'b0100, v, 1'b0);
        step();
        applyStimulus(4'b0010, v, 1'b0);
        step();
        applyStimulus(4'b0000, v, 1'b0);
        @(negedge clk);
        checkOutput("mid_level", 32'(level), 32'h3);
        checkOutput("mid_sum", 32'(sum_out), 32'h05);
        step();
        rst_n = 1'b0;
        applyStimulus(4'b1111, v, 1'b1);
        @(negedge clk);
        checkOutput("mid_rst_ack", 32'(bus.lane_ack), 32'h0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_level", 32'(level), 32'h0);
        checkOutput("post_rst_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("post_rst_sum", 32'(sum_out), 32'h0);
        checkOutput("post_rst_stall", 32'(stall_cnt), 32'h0);
        checkOutput("post_rst_ack", 32'(bus.lane_ack), 32'h1);
        step();
        applyStimulus(4'b0000, v, 1'b1);
        repeat (3) step();

        // Ten entries through the FIFO with out_ready toggling.
        doReset();
        v = 32'h44332211;
        for (int c = 0; c < 14; c++) begin
            applyStimulus(4'b1111, v, (c % 2) == 0);
            @(negedge clk);
            checkOutput($sformatf("wrap_ack%0d", c), 32'(bus.lane_ack), 32'(wrap_ack[c]));
            step();
        end
        applyStimulus(4'b0000, v, 1'b1);
        repeat (6) step();
        @(negedge clk);
        checkOutput("wrap_sum", 32'(sum_out), 32'h87);
        checkOutput("wrap_level", 32'(level), 32'h0);
        checkOutput("wrap_stall", 32'(stall_cnt), 32'h4);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
